ysyx_22040931_lsu_ctrl: RTL

- Load/store sequencer between the EXU and the data-memory bus. Accepts one decoded memory request at a time, carrying the 3-bit memrop load kind or a store size.
- Drives an AXI-lite-style read or write transaction and aligns/extends returned load data.
- Reports completion or error to the WBU with a one-cycle pulse.
- Stalls the pipeline through req_ready while busy.

---
 rtl/ysyx_22040931_lsu_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040931_lsu_ctrl.sv
// Load/store sequencer between the EXU and the data-memory bus.
// Takes one decoded memory request at a time and checks its alignment.
// Runs a single AXI-lite-style read or write and returns the aligned and
// extended load data, or an error code, as a one-cycle response pulse.
// Every output is a register or is decoded from the registered state, so
// no combinational path runs from req_* to mem_*.
module ysyx_22040931_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 32'd1023,
  parameter int unsigned ADDR_W      = 32'd64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [2:0]        memrop,
  input  logic [1:0]        wsize,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [63:0]       mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [ADDR_W-1:0] mem_awaddr,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_bvalid,
  output logic              mem_bready,
  input  logic [1:0]        mem_bresp
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  localparam logic [1:0]  ERR_OK_C    = 2'b00;
  localparam logic [1:0]  ERR_ALIGN_C = 2'b01;
  localparam logic [1:0]  ERR_BUS_C   = 2'b10;
  localparam logic [1:0]  ERR_TMO_C   = 2'b11;
  // A timeout of zero means the bus wait is never aborted.
  localparam bit          TMO_EN_C    = (TIMEOUT_CYC != 32'd0);
  localparam logic [31:0] TMO_LAST_C  = 32'(TIMEOUT_CYC - 32'd1);

  // Byte-strobe pattern for a store of the given size, before the lane shift.
  function automatic logic [7:0] strb_base(input logic [1:0] ws);
    case (ws)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      2'd3:    strb_base = 8'hFF;
      default: strb_base = 8'h00;
    endcase
  endfunction

  // Sign- or zero-extends the selected lane according to the load kind.
  function automatic logic [63:0] load_extend(input logic [2:0] op, input logic [63:0] lane);
    case (op)
      3'b001:  load_extend = {{56{lane[7]}}, lane[7:0]};
      3'b010:  load_extend = {{48{lane[15]}}, lane[15:0]};
      3'b011:  load_extend = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_extend = lane;
      3'b101:  load_extend = {56'd0, lane[7:0]};
      3'b110:  load_extend = {48'd0, lane[15:0]};
      3'b111:  load_extend = {32'd0, lane[31:0]};
      default: load_extend = 64'd0;
    endcase
  endfunction

  state_t            state_r;
  logic [2:0]        memrop_r;
  logic [ADDR_W-1:0] addr_r;
  logic [63:0]       wdata_r;
  logic [7:0]        wstrb_r;
  logic              aw_done_r;
  logic              w_done_r;
  logic [31:0]       cnt_r;
  logic [63:0]       rsp_rdata_r;
  logic [1:0]        rsp_err_r;

  logic              bad_req_s;
  logic              timeout_hit_s;
  logic [63:0]       lane_s;
  logic              aw_fin_s;
  logic              w_fin_s;

  // Flags a request that is misaligned for its access size or an illegal load.
  always_comb begin
    bad_req_s = 1'b0;
    if (req_load) begin
      case (memrop)
        3'b000:        bad_req_s = 1'b1;
        3'b010, 3'b110: bad_req_s = addr[0];
        3'b011, 3'b111: bad_req_s = |addr[1:0];
        3'b100:        bad_req_s = |addr[2:0];
        default:       bad_req_s = 1'b0;
      endcase
    end else begin
      case (wsize)
        2'd1:    bad_req_s = addr[0];
        2'd2:    bad_req_s = |addr[1:0];
        2'd3:    bad_req_s = |addr[2:0];
        default: bad_req_s = 1'b0;
      endcase
    end
  end

  // Raised in the last bus-wait cycle that is allowed before the abort.
  always_comb begin
    timeout_hit_s = 1'b0;
    if (TMO_EN_C && (cnt_r == TMO_LAST_C)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  assign lane_s   = mem_rdata >> {addr_r[2:0], 3'b000};
  // An address or data beat counts as done once it has handshaken, this cycle or earlier.
  assign aw_fin_s = aw_done_r | mem_awready;
  assign w_fin_s  = w_done_r  | mem_wready;

  // Sequencer: accepts, runs the bus phases and captures the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      memrop_r    <= 3'd0;
      addr_r      <= '0;
      wdata_r     <= 64'd0;
      wstrb_r     <= 8'd0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      cnt_r       <= 32'd0;
      rsp_rdata_r <= 64'd0;
      rsp_err_r   <= ERR_OK_C;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            memrop_r    <= memrop;
            addr_r      <= addr;
            wdata_r     <= wdata << {addr[2:0], 3'b000};
            wstrb_r     <= strb_base(wsize) << addr[2:0];
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            cnt_r       <= 32'd0;
            rsp_rdata_r <= 64'd0;
            if (bad_req_s) begin
              rsp_err_r <= ERR_ALIGN_C;
              state_r   <= ST_RESP;
            end else begin
              rsp_err_r <= ERR_OK_C;
              state_r   <= req_load ? ST_AR : ST_AW;
            end
          end
        end
        ST_AR: begin
          if (timeout_hit_s) begin
            rsp_err_r <= ERR_TMO_C;
            cnt_r     <= 32'd0;
            state_r   <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + 32'd1;
            if (mem_arready) begin
              state_r <= ST_R;
            end
          end
        end
        ST_R: begin
          if (timeout_hit_s) begin
            rsp_err_r <= ERR_TMO_C;
            cnt_r     <= 32'd0;
            state_r   <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + 32'd1;
            if (mem_rvalid) begin
              if (mem_rresp != 2'b00) begin
                rsp_err_r   <= ERR_BUS_C;
                rsp_rdata_r <= 64'd0;
              end else begin
                rsp_err_r   <= ERR_OK_C;
                rsp_rdata_r <= load_extend(memrop_r, lane_s);
              end
              state_r <= ST_RESP;
            end
          end
        end
        ST_AW: begin
          if (timeout_hit_s) begin
            rsp_err_r <= ERR_TMO_C;
            cnt_r     <= 32'd0;
            state_r   <= ST_RESP;
          end else begin
            cnt_r     <= cnt_r + 32'd1;
            aw_done_r <= aw_fin_s;
            w_done_r  <= w_fin_s;
            if (aw_fin_s && w_fin_s) begin
              state_r <= ST_B;
            end
          end
        end
        ST_B: begin
          if (timeout_hit_s) begin
            rsp_err_r <= ERR_TMO_C;
            cnt_r     <= 32'd0;
            state_r   <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + 32'd1;
            if (mem_bvalid) begin
              rsp_err_r <= (mem_bresp != 2'b00) ? ERR_BUS_C : ERR_OK_C;
              state_r   <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          cnt_r   <= 32'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_r == ST_IDLE);
  assign rsp_valid   = (state_r == ST_RESP);
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign mem_arvalid = (state_r == ST_AR);
  assign mem_araddr  = {addr_r[ADDR_W-1:3], 3'b000};
  assign mem_rready  = (state_r == ST_R);
  assign mem_awvalid = (state_r == ST_AW) && !aw_done_r;
  assign mem_awaddr  = {addr_r[ADDR_W-1:3], 3'b000};
  assign mem_wvalid  = (state_r == ST_AW) && !w_done_r;
  assign mem_wdata   = wdata_r;
  assign mem_wstrb   = wstrb_r;
  assign mem_bready  = (state_r == ST_B);

endmodule
